// File: rtl/skolem_sweep_if.sv
// Handshake and result bundle between a sweep controller and the Skolem-function
// evaluator.
//   start/abort  : sweep control requests
//   vec_o        : assignment under test, bit k drives function input ik
//   f_i          : function output for vec_o, combinational in the same cycle
//   busy/done    : sweep status
//   ones_cnt, first_one, first_valid, sig : sweep results
// Modports:
//   master : the requester and evaluator side
//   slave  : the sweep engine
interface skolem_sweep_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic         abort;
  logic [N-1:0] vec_o;
  logic         f_i;
  logic         busy;
  logic         done;
  logic [N:0]   ones_cnt;
  logic [N-1:0] first_one;
  logic         first_valid;
  logic [15:0]  sig;

  modport master (
    output start, abort, f_i,
    input  vec_o, busy, done, ones_cnt, first_one, first_valid, sig
  );

  modport slave (
    input  start, abort, f_i,
    output vec_o, busy, done, ones_cnt, first_one, first_valid, sig
  );
endinterface

// File: rtl/skolem_sweep.sv
// Exhaustive sweep of all 2^N assignments of an external Skolem function.
// Each SWEEP cycle samples f_i for the current vec_o, counts ones, captures
// the lowest satisfying assignment and folds f_i into a 16-bit MISR.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : skolem_sweep_if slave modport (control, assignment, results)
module skolem_sweep #(
  parameter int unsigned N = 8
) (
  input logic           clk,
  input logic           rst,
  skolem_sweep_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  localparam logic [15:0] SigSeed = 16'hFFFF;
  localparam logic [15:0] SigPoly = 16'h1021;

  state_e      state_q;
  logic [15:0] sig_next;

  // Shift left, then fold in the polynomial when the outgoing bit differs from f_i.
  always_comb begin
    sig_next = {bus.sig[14:0], 1'b0};
    if (bus.sig[15] ^ bus.f_i) begin
      sig_next = sig_next ^ SigPoly;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      bus.vec_o       <= '0;
      bus.ones_cnt    <= '0;
      bus.first_one   <= '0;
      bus.first_valid <= 1'b0;
      bus.sig         <= SigSeed;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Abort wins over a simultaneous start.
          if (bus.start && !bus.abort) begin
            state_q         <= StSweep;
            bus.busy        <= 1'b1;
            bus.vec_o       <= '0;
            bus.ones_cnt    <= '0;
            bus.first_one   <= '0;
            bus.first_valid <= 1'b0;
            bus.sig         <= SigSeed;
          end
        end
        StSweep: begin
          if (bus.abort) begin
            // Leave partial results visible; this cycle's f_i is not sampled.
            state_q  <= StIdle;
            bus.busy <= 1'b0;
          end else begin
            if (bus.f_i) begin
              bus.ones_cnt <= bus.ones_cnt + {{N{1'b0}}, 1'b1};
              if (!bus.first_valid) begin
                bus.first_one   <= bus.vec_o;
                bus.first_valid <= 1'b1;
              end
            end
            bus.sig   <= sig_next;
            bus.vec_o <= bus.vec_o + {{(N-1){1'b0}}, 1'b1};
            if (bus.vec_o == {N{1'b1}}) begin
              state_q  <= StDone;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q  <= StIdle;
          bus.done <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_sweep.sv
// Directed bench for skolem_sweep with N=8. The Skolem function is modelled
// combinationally from vec_o according to fmode.
module tb_skolem_sweep;

  localparam int unsigned N = 8;

  logic clk;
  logic rst;
  int   fmode;
  int   checks;
  int   failures;

  skolem_sweep_if #(.N(N)) bus ();

  skolem_sweep #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: tied low, 1: tied high, 2: high only at A5 and F0, 3: toggling garbage
  always_comb begin
    case (fmode)
      0:       bus.f_i = 1'b0;
      1:       bus.f_i = 1'b1;
      2:       bus.f_i = (bus.vec_o == 8'hA5) || (bus.vec_o == 8'hF0);
      default: bus.f_i = clk;
    endcase
  end

  function automatic logic [15:0] sig_model(input int mode);
    logic [15:0] s;
    logic        f;
    s = 16'hFFFF;
    for (int v = 0; v < 256; v++) begin
      if (mode == 0)      f = 1'b0;
      else if (mode == 1) f = 1'b1;
      else                f = (v == 'hA5) || (v == 'hF0);
      s = {s[14:0], 1'b0} ^ ((s[15] ^ f) ? 16'h1021 : 16'h0000);
    end
    return s;
  endfunction

  // Pulse start for one cycle; returns after the accepting edge.
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count busy cycles until done is seen, bounded.
  task automatic wait_done(output int cycles, output bit got_done);
    cycles   = 0;
    got_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      if (bus.busy) cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0h want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got %0h want 0", bus.done); end
    checks++; if (bus.vec_o !== 8'h00) begin failures++; $display("FAIL reset_vec got %0h want 0", bus.vec_o); end
    checks++; if (bus.ones_cnt !== 9'd0) begin failures++; $display("FAIL reset_ones got %0d want 0", bus.ones_cnt); end
    checks++; if (bus.first_valid !== 1'b0) begin failures++; $display("FAIL reset_fvalid got %0h want 0", bus.first_valid); end
    checks++; if (bus.sig !== 16'hFFFF) begin failures++; $display("FAIL reset_sig got %0h want ffff", bus.sig); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep_zero();
    int cycles;
    bit got;
    fmode = 0;
    pulse_start();
    wait_done(cycles, got);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL zero_done_seen got %0d want 1", got); end
    checks++; if (cycles != 256) begin failures++; $display("FAIL zero_busy_cycles got %0d want 256", cycles); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL zero_done_width got %0h want 0", bus.done); end
    checks++; if (bus.ones_cnt !== 9'd0) begin failures++; $display("FAIL zero_ones got %0d want 0", bus.ones_cnt); end
    checks++; if (bus.first_valid !== 1'b0) begin failures++; $display("FAIL zero_fvalid got %0h want 0", bus.first_valid); end
    checks++; if (bus.vec_o !== 8'h00) begin failures++; $display("FAIL zero_vec_wrap got %0h want 0", bus.vec_o); end
    checks++; if (bus.sig !== sig_model(0)) begin failures++; $display("FAIL zero_sig got %0h want %0h", bus.sig, sig_model(0)); end
  endtask

  task automatic test_sweep_ones();
    int cycles;
    bit got;
    fmode = 1;
    pulse_start();
    wait_done(cycles, got);
    checks++; if (got !== 1'b1 || cycles != 256) begin failures++; $display("FAIL ones_latency got %0d/%0d want 256/1", cycles, got); end
    @(negedge clk);
    checks++; if (bus.ones_cnt !== 9'd256) begin failures++; $display("FAIL ones_cnt got %0d want 256", bus.ones_cnt); end
    checks++; if (bus.first_one !== 8'h00) begin failures++; $display("FAIL ones_first got %0h want 0", bus.first_one); end
    checks++; if (bus.first_valid !== 1'b1) begin failures++; $display("FAIL ones_fvalid got %0h want 1", bus.first_valid); end
    checks++; if (bus.sig !== sig_model(1)) begin failures++; $display("FAIL ones_sig got %0h want %0h", bus.sig, sig_model(1)); end
  endtask

  task automatic test_sparse_and_hold();
    int cycles;
    bit got;
    logic [15:0] s;
    fmode = 2;
    pulse_start();
    wait_done(cycles, got);
    checks++; if (got !== 1'b1 || cycles != 256) begin failures++; $display("FAIL sparse_latency got %0d/%0d want 256/1", cycles, got); end
    @(negedge clk);
    checks++; if (bus.ones_cnt !== 9'd2) begin failures++; $display("FAIL sparse_ones got %0d want 2", bus.ones_cnt); end
    checks++; if (bus.first_one !== 8'hA5) begin failures++; $display("FAIL sparse_first got %0h want a5", bus.first_one); end
    s = sig_model(2);
    checks++; if (bus.sig !== s) begin failures++; $display("FAIL sparse_sig got %0h want %0h", bus.sig, s); end
    // Results hold in IDLE and f_i is ignored there.
    fmode = 1;
    repeat (5) @(negedge clk);
    checks++; if (bus.ones_cnt !== 9'd2 || bus.sig !== s || bus.busy !== 1'b0) begin
      failures++; $display("FAIL idle_hold got ones=%0d sig=%0h busy=%0h want 2/%0h/0", bus.ones_cnt, bus.sig, bus.busy, s);
    end
  endtask

  task automatic test_abort();
    bit saw_done;
    fmode = 1;
    pulse_start();
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got %0h want 0", bus.busy); end
    checks++; if (bus.ones_cnt !== 9'd9) begin failures++; $display("FAIL abort_ones got %0d want 9", bus.ones_cnt); end
    checks++; if (bus.vec_o !== 8'd9 || bus.first_valid !== 1'b1) begin
      failures++; $display("FAIL abort_partial got vec=%0d fv=%0h want 9/1", bus.vec_o, bus.first_valid);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done || bus.busy) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_quiet got %0d want 0", saw_done); end
    // Abort and start together in IDLE: stay idle.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.ones_cnt !== 9'd9) begin
      failures++; $display("FAIL abort_wins got busy=%0h ones=%0d want 0/9", bus.busy, bus.ones_cnt);
    end
  endtask

  task automatic test_start_ignored();
    int cycles;
    bit got;
    fmode = 0;
    pulse_start();
    cycles = 0;
    got    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.busy) cycles++;
      bus.start = (cycles == 50);
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++; if (got !== 1'b1 || cycles != 256) begin failures++; $display("FAIL restart_ignored got %0d/%0d want 256/1", cycles, got); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL after_done_idle got busy=%0h done=%0h want 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cycles;
    bit got;
    fmode = 1;
    pulse_start();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.ones_cnt !== 9'd0 || bus.vec_o !== 8'h00) begin
      failures++; $display("FAIL rst_mid got busy=%0h ones=%0d vec=%0h want 0/0/0", bus.busy, bus.ones_cnt, bus.vec_o);
    end
    checks++; if (bus.sig !== 16'hFFFF || bus.first_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_sig got sig=%0h fv=%0h want ffff/0", bus.sig, bus.first_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_release_idle got %0h want 0", bus.busy); end
    fmode = 2;
    pulse_start();
    wait_done(cycles, got);
    @(negedge clk);
    checks++; if (got !== 1'b1 || cycles != 256 || bus.ones_cnt !== 9'd2 || bus.first_one !== 8'hA5) begin
      failures++; $display("FAIL rst_resweep got cyc=%0d ones=%0d first=%0h want 256/2/a5", cycles, bus.ones_cnt, bus.first_one);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    fmode     = 0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b0;
    test_reset();
    test_sweep_zero();
    test_sweep_ones();
    test_sparse_and_hold();
    test_abort();
    test_start_ignored();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
